// File: rtl/alu_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler_if
// Bundles the requester handshake, the shared-ALU operand/result bus and the
// response bus of alu_rr_scheduler.
//   req_valid/req_ready   per-requester offer and combinational accept
//   req_a/req_b/req_fun   packed per-requester payload (requester i at slot i)
//   alu_a/alu_b/alu_fun   registered operands/function to the shared ALU
//   alu_out               registered ALU result (WIDTH+1 bits)
//   rsp_valid/rsp_data    one-cycle result pulse to the owning requester
//   rsp_id                index of the current/last granted requester
//   busy                  scheduler not idle
// modport master: client/ALU side.  modport slave: the scheduler.
// ---------------------------------------------------------------------------
interface alu_rr_scheduler_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*2-1:0]     req_fun;
    logic [WIDTH-1:0]         alu_a;
    logic [WIDTH-1:0]         alu_b;
    logic [1:0]               alu_fun;
    logic [WIDTH:0]           alu_out;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH:0]           rsp_data;
    logic [ID_W-1:0]          rsp_id;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, req_fun, alu_out,
        input  req_ready, alu_a, alu_b, alu_fun, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_fun, alu_out,
        output req_ready, alu_a, alu_b, alu_fun, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
// Shares one registered ALU between NUM_REQ requesters with round-robin
// arbitration. One operation is in flight at a time: accept, issue, wait out
// the ALU register, then pulse the result back to the granted requester.
// Ports:
//   CLK   clock, rising edge
//   RST   synchronous active-high reset
//   bus   alu_rr_scheduler_if.slave (handshake, ALU bus, response bus)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | arbitrate; accept winner and load ALU operands at the edge
// ISSUE | operands stable; ALU registers the result at the end of this cycle
// WAIT  | capture alu_out into rsp_data and arm rsp_valid
// RESP  | rsp_valid high for this single cycle
// ---------------------------------------------------------------------------
module alu_rr_scheduler #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               CLK,
    input  logic               RST,
    alu_rr_scheduler_if.slave  bus
);
    localparam int IW = ID_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [1:0]         alu_fun_q, alu_fun_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [WIDTH:0]     rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [NUM_REQ-1:0]   valid_rot;
    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;
    logic [IW-1:0]        grant_sum;
    logic [WIDTH-1:0]     sel_a, sel_b;
    logic [1:0]           sel_fun;
    logic                 accept;
    logic [NUM_REQ-1:0]   ready;
    logic [NUM_REQ-1:0]   id_onehot;

    // Rotate the valid vector so that bit 0 is the requester at rr_ptr; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    always_comb begin
        valid_dbl   = {bus.req_valid, bus.req_valid};
        valid_rot   = NUM_REQ'(valid_dbl >> rr_ptr_q);
        grant_found = 1'b0;
        grant_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                grant_found = 1'b1;
                grant_sum   = {1'b0, rr_ptr_q} + IW'(k);
            end
        end
        // rr_ptr < NUM_REQ, so one subtraction completes the wrap.
        if (grant_sum >= IW'(NUM_REQ)) begin
            grant_sum = grant_sum - IW'(NUM_REQ);
        end
        grant_idx = grant_sum[ID_W-1:0];
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_fun   = '0;
        ready     = '0;
        id_onehot = '0;
        accept    = (state_q == IDLE) && grant_found && !RST;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a    = bus.req_a[i*WIDTH +: WIDTH];
                sel_b    = bus.req_b[i*WIDTH +: WIDTH];
                sel_fun  = bus.req_fun[i*2 +: 2];
                ready[i] = accept;
            end
            if (rsp_id_q == ID_W'(i)) begin
                id_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fun_d   = alu_fun_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    alu_a_d   = sel_a;
                    alu_b_d   = sel_b;
                    alu_fun_d = sel_fun;
                    rsp_id_d  = grant_idx;
                    rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                                  : grant_idx + ID_W'(1);
                    state_d   = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                rsp_data_d  = bus.alu_out;
                rsp_valid_d = id_onehot;
                state_d     = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fun_q   <= alu_fun_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_fun   = alu_fun_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state_q != IDLE) && !RST;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
// Directed bench for alu_rr_scheduler with a behavioural registered ALU
// (00 add, 01 subtract, 10 and, 11 or; one-cycle latency).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_rr_scheduler;
    logic CLK;
    logic RST;
    int   n_assert = 0;
    int   n_fail   = 0;

    alu_rr_scheduler_if #(.WIDTH(16), .NUM_REQ(4), .ID_W(2)) bus ();

    alu_rr_scheduler #(.WIDTH(16), .NUM_REQ(4), .ID_W(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] f);
        case (f)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    always @(posedge CLK) bus.alu_out <= alu_f(bus.alu_a, bus.alu_b, bus.alu_fun);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] f);
        bus.req_a[id*16 +: 16] = a;
        bus.req_b[id*16 +: 16] = b;
        bus.req_fun[id*2 +: 2] = f;
    endtask

    // Full single operation from requester id; starts and ends in an IDLE cycle.
    task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] f, input logic [16:0] exp);
        bus.req_valid = '0;
        set_req(id, a, b, f);
        bus.req_valid[id] = 1'b1;
        #1;
        chk("accept_ready", 32'(bus.req_ready), 32'(1 << id));
        chk("accept_busy", 32'(bus.busy), 32'd0);
        tick();
        bus.req_valid = '0;
        chk("issue_alu_a", 32'(bus.alu_a), 32'(a));
        chk("issue_alu_b", 32'(bus.alu_b), 32'(b));
        chk("issue_alu_fun", 32'(bus.alu_fun), 32'(f));
        chk("issue_rsp_id", 32'(bus.rsp_id), 32'(id));
        chk("issue_busy", 32'(bus.busy), 32'd1);
        chk("issue_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("wait_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("resp_rsp_valid", 32'(bus.rsp_valid), 32'(1 << id));
        chk("resp_rsp_data", 32'(bus.rsp_data), 32'(exp));
        chk("resp_rsp_id", 32'(bus.rsp_id), 32'(id));
        chk("resp_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_rsp_data_hold", 32'(bus.rsp_data), 32'(exp));
    endtask

    // One arbitration round with payload A=0x1000+i, B=i, add, valids left as set.
    task automatic run_grant(input int g);
        #1;
        chk("rr_ready", 32'(bus.req_ready), 32'(1 << g));
        tick();
        chk("rr_alu_a", 32'(bus.alu_a), 32'h1000 + 32'(g));
        chk("rr_rsp_id", 32'(bus.rsp_id), 32'(g));
        tick();
        tick();
        chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'(1 << g));
        chk("rr_rsp_data", 32'(bus.rsp_data), 32'h1000 + 32'(2 * g));
        chk("rr_rsp_id_resp", 32'(bus.rsp_id), 32'(g));
        tick();
        chk("rr_rsp_clear", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        RST           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_fun   = '0;

        // Reset state; valids asserted during reset must not be accepted.
        tick();
        bus.req_valid = 4'b1111;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
        chk("rst_alu_fun", 32'(bus.alu_fun), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        bus.req_valid = '0;
        RST           = 1'b0;

        // Add with carry into bit 16, then subtract/and/or from requester 0.
        do_op(1, 16'hFFFF, 16'h0001, 2'b00, 17'h10000);
        do_op(0, 16'h0003, 16'h0005, 2'b01, 17'h1FFFE);
        do_op(0, 16'hF0F0, 16'h3C3C, 2'b10, 17'h03030);
        do_op(0, 16'hF0F0, 16'h3C3C, 2'b11, 17'h0FCFC);

        // Fresh reset puts rr_ptr at 0; all four valid continuously.
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 16'h1000 + 16'(i), 16'(i), 2'b00);
        bus.req_valid = 4'b1111;
        run_grant(0);
        run_grant(1);
        run_grant(2);
        run_grant(3);
        run_grant(0);

        // rr_ptr=1 with only requesters 0 and 2 valid: 2, then wrap to 0, then 2.
        bus.req_valid = 4'b0101;
        run_grant(2);
        run_grant(0);
        run_grant(2);
        bus.req_valid = '0;

        // Reset during WAIT aborts the operation with no response.
        set_req(1, 16'h0055, 16'h0011, 2'b00);
        bus.req_valid = 4'b0010;
        #1;
        chk("abort_ready", 32'(bus.req_ready), 32'b0010);
        tick();
        bus.req_valid = '0;
        chk("abort_issue_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("abort_wait_busy", 32'(bus.busy), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_alu_a", 32'(bus.alu_a), 32'd0);
        chk("abort_alu_b", 32'(bus.alu_b), 32'd0);
        chk("abort_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("abort_rsp_id", 32'(bus.rsp_id), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        do_op(3, 16'h1234, 16'h0F0F, 2'b00, 17'h02143);

        // Requester 1 waits behind requester 0, then withdraws before a grant.
        set_req(0, 16'h0100, 16'h0023, 2'b00);
        set_req(1, 16'hAAAA, 16'h5555, 2'b11);
        bus.req_valid = 4'b0011;
        #1;
        chk("drop_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        bus.req_valid[0] = 1'b0;
        #1;
        chk("drop_busy_ready", 32'(bus.req_ready), 32'd0);
        tick();
        bus.req_valid[1] = 1'b0;
        chk("drop_wait_ready", 32'(bus.req_ready), 32'd0);
        tick();
        chk("drop_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
        chk("drop_rsp_data", 32'(bus.rsp_data), 32'h00123);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("drop_no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("drop_idle", 32'(bus.busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Shares one registered 16-bit ALU between NUM_REQ requesters using round-robin arbitration. Each requester offers an operation (A, B, 2-bit function) over a valid/ready handshake. The block drives the shared ALU's operand/function inputs and waits out its one-cycle register latency. It then returns the (WIDTH+1)-bit result to the granted requester as a one-cycle response pulse. It sits between client engines and the ALU instance; the ALU's own reset is driven separately.

Parameters:
WIDTH, 16, operand width; result width is WIDTH+1
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index; must satisfy 2**ID_W >= NUM_REQ

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester operation offered
req_ready  output  NUM_REQ  per-requester accept, combinational, one-hot or zero
req_a  input  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  operand B, same packing
req_fun  input  NUM_REQ*2  function code, requester i at bits [i*2 +: 2]
alu_a  output  WIDTH  to ALU A, registered
alu_b  output  WIDTH  to ALU B, registered
alu_fun  output  2  to ALU_FUN, registered
alu_out  input  WIDTH+1  from ALU_OUT
rsp_valid  output  NUM_REQ  one-cycle result pulse to the owning requester, registered
rsp_data  output  WIDTH+1  result, valid while any rsp_valid bit is high
rsp_id  output  ID_W  index of the current/last granted requester
busy  output  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Each non-IDLE state lasts exactly one cycle.
- IDLE:
  - If any req_valid is set, select winner g by scanning from rr_ptr upward with wrap-around.
  - req_ready[g]=1 combinationally in that same cycle.
  - At the edge: alu_a/alu_b/alu_fun <= requester g payload; rsp_id <= g; rr_ptr <= (g+1) mod NUM_REQ; state -> ISSUE.
  - If no req_valid is set, nothing changes.
- ISSUE: alu_* held stable; the ALU registers the result at the end of this cycle; state -> WAIT.
- WAIT: rsp_data <= alu_out; rsp_valid <= one-hot(rsp_id); state -> RESP.
- RESP: rsp_valid high for this single cycle; state -> IDLE; rsp_valid cleared at the edge.
- req_ready is 0 in every state except IDLE. No new accept happens while busy.
- Timing:
  - Accept at cycle 0; rsp_valid high in cycle 3.
  - Next accept is possible at the earliest in cycle 4.
  - Throughput is one op per 4 cycles.
- Result is passed through unmodified, with no width manipulation. Add carry appears in bit WIDTH. Subtract borrow wraps modulo 2**(WIDTH+1).
- Handshake rules:
  - A requester holds payload stable while req_valid is high and its req_ready is low.
  - Dropping req_valid before grant is legal and that requester is skipped.
  - req_valid during another requester's operation only waits; it is not queued internally.
- Fairness: a requester continuously asserting valid is granted within NUM_REQ accepts. A lone requester may be granted back-to-back.
- rsp_data and rsp_id hold their last values outside RESP.
- Reset behaviour:
  - RST high at an edge forces state=IDLE, rr_ptr=0, alu_a=alu_b=0, alu_fun=0, rsp_valid=0, rsp_data=0, rsp_id=0.
  - req_ready=0 and busy=0 while RST is high.
  - Reset mid-operation aborts it silently: no rsp_valid is ever produced for it.
- RST overrides all other activity in the same cycle.

Test Plan:
- Reset, then single add from req 1 (A=16'hFFFF, B=16'h0001, fun=00) -> req_ready[1] in accept cycle; rsp_valid=4'b0010 exactly 3 cycles later with rsp_data=17'h10000, rsp_id=1, busy high for 3 cycles.
- Subtract from req 0 (A=3, B=5, fun=01) -> rsp_data=17'h1FFFE; AND (A=16'hF0F0, B=16'h3C3C, fun=10) -> 17'h03030; OR (same operands, fun=11) -> 17'h0FCFC.
- All four req_valid held high continuously, each with a distinct A -> grants in order 0,1,2,3,0. Accepts are 4 cycles apart, each rsp_data/rsp_id matches its requester, and exactly one rsp_valid bit is set per response.
- After a grant to req 2, only req 2 and req 0 stay valid -> next grant goes to 0 (wrap from rr_ptr=3), then to 2.
- Assert RST in the WAIT cycle of an operation -> no rsp_valid is ever produced, outputs are at reset values the next cycle, and a following request from req 3 is granted by req 3 and completes normally.
- req 1 raises valid, then drops it while req 0's op is in flight -> req 1 is never granted and no response is issued to it.
